// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared state encoding and default geometry for the scratch memory controller
package rom_ctrl_pkg;
  localparam int DEFAULT_AW = 5;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_INIT_WORDS = 16;
  typedef enum logic [1:0] {INIT, IDLE, ACC, WAIT} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; pointer flips to the loser after every grant
module rr_arbiter2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;
  assign grant = &req ? (ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
endmodule

// File: rtl/rom_access_ctrl.sv
// rom_access_ctrl: init sweep plus round-robin sharing of the single memory port
module rom_access_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int n = 8,
  parameter int AW = DEFAULT_AW,
  parameter int INIT_WORDS = DEFAULT_INIT_WORDS
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          init_req,
  output logic          busy_init,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic          r0_we,
  input  logic          r1_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [AW-1:0] r1_addr,
  input  logic [n-1:0]  r0_wdata,
  input  logic [n-1:0]  r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_done,
  output logic          r1_done,
  output logic [n-1:0]  r0_rdata,
  output logic [n-1:0]  r1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [n-1:0]  mem_d,
  input  logic [n-1:0]  mem_q
);
  state_t state;
  logic [AW:0] cnt;
  logic [1:0] grant;
  logic cur, cur_we, sel, we_s, advance;
  logic [AW-1:0] addr_s;
  logic [n-1:0] wdata_s;
  assign sel = grant[1];
  assign we_s = sel ? r1_we : r0_we;
  assign addr_s = sel ? r1_addr : r0_addr;
  assign wdata_s = sel ? r1_wdata : r0_wdata;
  assign advance = (state == IDLE || state == WAIT) && !init_req && (r0_req || r1_req);
  rr_arbiter2 u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    ({r1_req, r0_req}),
    .advance(advance),
    .grant  (grant)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      cnt <= '0;
      busy_init <= 1'b1;
      cur <= 1'b0;
      cur_we <= 1'b0;
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_d <= '0;
    end else begin
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_d <= '0;
      // the access issued two edges ago completes here, whatever is decided next
      if (state == WAIT) begin
        r0_done <= !cur;
        r1_done <= cur;
        if (!cur_we && cur) r1_rdata <= mem_q;
        if (!cur_we && !cur) r0_rdata <= mem_q;
      end
      if (state == INIT) begin
        if (cnt[AW]) begin
          state <= IDLE;
          busy_init <= 1'b0;
        end else begin
          mem_we <= 1'b1;
          mem_addr <= cnt[AW-1:0];
          mem_d <= int'(cnt) < INIT_WORDS ? n'(cnt[AW-1:0]) : '0;
          cnt <= cnt + 1'b1;
        end
      end else if (state == ACC) state <= WAIT;
      else if (init_req) begin
        state <= INIT;
        cnt <= '0;
        busy_init <= 1'b1;
      end else if (advance) begin
        state <= ACC;
        cur <= sel;
        cur_we <= we_s;
        mem_we <= we_s;
        mem_addr <= addr_s;
        mem_d <= wdata_s;
        r0_gnt <= !sel;
        r1_gnt <= sel;
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb_rom_access_ctrl: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_rom_access_ctrl;
  logic clock = 0, resetn = 0, init_req = 0, busy_init;
  logic r0_req = 0, r1_req = 0, r0_we = 0, r1_we = 0;
  logic [4:0] r0_addr = 0, r1_addr = 0, mem_addr;
  logic [7:0] r0_wdata = 0, r1_wdata = 0, r0_rdata, r1_rdata, mem_d, mem_q;
  logic r0_gnt, r1_gnt, r0_done, r1_done, mem_we;
  logic [7:0] mem [32];
  logic [7:0] exp_rd [2];
  typedef struct packed {logic who; logic we; logic [4:0] addr; logic [7:0] d;} ev_t;
  ev_t gnt_q[$], done_q[$], e;
  int gnt_cyc[$];
  int cyc = 0, last_gnt = -1, c, cmp = 0, mis = 0, ng;
  bit b2b = 0;

  rom_access_ctrl dut (
    .clock(clock), .resetn(resetn), .init_req(init_req), .busy_init(busy_init),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    mem_q = 8'h00;
  end
  always @(posedge clock)
    if (mem_we) mem[mem_addr] <= mem_d;
    else mem_q <= mem[mem_addr];

  initial exp_rd = '{8'h00, 8'h00};

  always @(negedge clock) if (resetn) begin
    if (r0_done || r1_done) begin
      cmp++;
      if (done_q.size() == 0 || gnt_cyc.size() == 0) begin
        mis++;
        $display("FAIL done_unexpected: r1_done=%b r0_done=%b, required none", r1_done, r0_done);
      end else begin
        e = done_q.pop_front();
        c = gnt_cyc.pop_front();
        if (!e.we) exp_rd[e.who] = e.d;
        if ({r1_done, r0_done} != (e.who ? 2'b10 : 2'b01) || cyc - c != 2 ||
            r0_rdata != exp_rd[0] || r1_rdata != exp_rd[1]) begin
          mis++;
          $display("FAIL done: got r1r0=%b lat=%0d r0_rdata=%h r1_rdata=%h, required r1r0=%b lat=2 r0_rdata=%h r1_rdata=%h",
                   {r1_done, r0_done}, cyc - c, r0_rdata, r1_rdata, e.who ? 2'b10 : 2'b01, exp_rd[0], exp_rd[1]);
        end
      end
    end
    if (r0_gnt || r1_gnt) begin
      cmp++;
      if (gnt_q.size() == 0) begin
        mis++;
        $display("FAIL gnt_unexpected: r1_gnt=%b r0_gnt=%b, required none", r1_gnt, r0_gnt);
      end else begin
        e = gnt_q.pop_front();
        if ({r1_gnt, r0_gnt} != (e.who ? 2'b10 : 2'b01) || mem_we != e.we || mem_addr != e.addr ||
            (e.we && mem_d != e.d) || (b2b && last_gnt >= 0 && cyc - last_gnt != 2)) begin
          mis++;
          $display("FAIL gnt: got r1r0=%b we=%b addr=%0d d=%h gap=%0d, required r1r0=%b we=%b addr=%0d d=%h gap=2",
                   {r1_gnt, r0_gnt}, mem_we, mem_addr, mem_d, cyc - last_gnt,
                   e.who ? 2'b10 : 2'b01, e.we, e.addr, e.d);
        end
      end
      gnt_cyc.push_back(cyc);
      last_gnt = cyc;
    end
  end

  task automatic fail_now(input string name);
    cmp++;
    mis++;
    $display("FAIL %s: bound expired, required event", name);
  endtask

  task automatic expect_acc(input bit who, input bit we, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] rd);
    gnt_q.push_back('{who, we, a, wd});
    done_q.push_back('{who, we, a, rd});
  endtask

  task automatic drive(input bit who, input bit we, input logic [4:0] a, input logic [7:0] wd);
    if (who) begin r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1; end
    else begin r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1; end
  endtask

  task automatic wait_sig(input bit who, input bit dn, input string name);
    for (int i = 0; i < 40; i++) begin
      if (dn ? (who ? r1_done : r0_done) : (who ? r1_gnt : r0_gnt)) return;
      @(posedge clock); #1;
    end
    fail_now(name);
  endtask

  task automatic access(input bit who, input bit we, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] rd);
    expect_acc(who, we, a, wd, rd);
    @(posedge clock); #1;
    drive(who, we, a, wd);
    @(posedge clock); #1;
    wait_sig(who, 0, "gnt_wait");
    r0_req = 0;
    r1_req = 0;
    wait_sig(who, 1, "done_wait");
  endtask

  task automatic check_reset();
    cmp++;
    if ({busy_init, mem_we, mem_addr, mem_d, r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata} != {1'b1, 34'b0}) begin
      mis++;
      $display("FAIL reset: busy=%b we=%b addr=%0d d=%h gnt=%b%b done=%b%b rd=%h/%h, required busy=1 rest 0",
               busy_init, mem_we, mem_addr, mem_d, r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata);
    end
  endtask

  task automatic sweep_check();
    logic [7:0] ed;
    for (int i = 0; i < 40 && !mem_we; i++) begin @(posedge clock); #1; end
    for (int k = 0; k < 32; k++) begin
      ed = k < 16 ? 8'(k) : 8'h00;
      cmp++;
      if (!(mem_we && mem_addr == 5'(k) && mem_d == ed && busy_init && !r0_gnt && !r1_gnt)) begin
        mis++;
        $display("FAIL sweep_%0d: we=%b addr=%0d d=%h busy=%b gnt=%b%b, required we=1 addr=%0d d=%h busy=1 gnt=00",
                 k, mem_we, mem_addr, mem_d, busy_init, r0_gnt, r1_gnt, k, ed);
      end
      @(posedge clock); #1;
    end
    cmp++;
    if (busy_init || mem_we || mem_addr != 0) begin
      mis++;
      $display("FAIL sweep_end: busy=%b we=%b addr=%0d, required 0 0 0", busy_init, mem_we, mem_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 check_reset();
    @(posedge clock); #1 resetn = 1;
    sweep_check();
    access(0, 0, 5'd5, 8'h00, 8'h05);
    access(1, 1, 5'd20, 8'hA5, 8'h00);
    access(0, 0, 5'd20, 8'h00, 8'hA5);
    expect_acc(1, 0, 5'd20, 8'h00, 8'h00);
    @(posedge clock); #1;
    init_req = 1;
    drive(1, 0, 5'd20, 8'h00);
    @(posedge clock); #1 init_req = 0;
    sweep_check();
    @(posedge clock); #1;
    cmp++;
    if (!r1_gnt) begin mis++; $display("FAIL gnt_after_init: r1_gnt=%b, required 1", r1_gnt); end
    r1_req = 0;
    wait_sig(1, 1, "done_after_init");
    for (int i = 0; i < 3; i++) begin
      expect_acc(0, 0, 5'd1, 8'h00, 8'h01);
      expect_acc(1, 0, 5'd2, 8'h00, 8'h02);
    end
    b2b = 1;
    last_gnt = -1;
    @(posedge clock); #1;
    drive(0, 0, 5'd1, 8'h00);
    drive(1, 0, 5'd2, 8'h00);
    ng = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(posedge clock); #1;
      if (r0_gnt || r1_gnt) ng++;
    end
    r0_req = 0;
    r1_req = 0;
    if (ng < 6) fail_now("rr_gnts");
    repeat (3) begin @(posedge clock); #1; end
    b2b = 0;
    gnt_q.push_back('{1'b0, 1'b0, 5'd5, 8'h00});
    @(posedge clock); #1;
    drive(0, 0, 5'd5, 8'h00);
    @(posedge clock); #1;
    wait_sig(0, 0, "gnt_before_reset");
    r0_req = 0;
    @(negedge clock); #1;
    gnt_q.delete();
    done_q.delete();
    gnt_cyc.delete();
    exp_rd = '{8'h00, 8'h00};
    resetn = 0;
    #1 check_reset();
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    sweep_check();
    access(1, 0, 5'd7, 8'h00, 8'h07);
    access(0, 0, 5'd20, 8'h00, 8'h00);
    repeat (4) @(posedge clock);
    cmp++;
    if (gnt_q.size() != 0 || done_q.size() != 0) begin
      mis++;
      $display("FAIL queues_drained: gnt_q=%0d done_q=%0d, required 0 0", gnt_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/rom_access_ctrl.md
# rom_access_ctrl

Sequencing and arbitration controller for the processor's 32-word scratch ROM/RAM. After reset or on demand it writes the default image into the memory. Otherwise it shares the single memory port between two requesters, requester 0 (fetch) and requester 1 (loader), with a req/gnt/done handshake and round-robin fairness. It sits between the requesters and the memory macro, and is the only block that drives that macro's WE, address and data pins.

## Interface
- n, 8: data width
- AW, 5: address width; memory depth is 2^AW words
- INIT_WORDS, 16: init image writes value = address for addresses below this; all other addresses get 0
- clock  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- init_req  in  1  request a full init sweep
- busy_init  out  1  high while the init sweep runs
- r0_req, r1_req  in  1  access request; held until gnt
- r0_we, r1_we  in  1  1 = write, 0 = read; stable while req is high
- r0_addr, r1_addr  in  AW  word address; stable while req is high
- r0_wdata, r1_wdata  in  n  write data; stable while req is high
- r0_gnt, r1_gnt  out  1  one-cycle pulse: access issued
- r0_done, r1_done  out  1  one-cycle pulse: access complete
- r0_rdata, r1_rdata  out  n  read result; held until that requester's next read completes
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_d  out  n  memory write data
- mem_q  in  n  memory read data

## Operation
- Memory contract: on a rising edge with mem_we=1 the macro writes mem_d to mem_addr. With mem_we=0 it registers the word at mem_addr onto mem_q, giving one-cycle read latency.
- States:
  - INIT: sweep counter 0..2^AW-1, one write per cycle.
  - IDLE: samples init_req and requests.
  - ACC: access outputs driven.
  - WAIT: memory completing.
- Transitions:
  - Reset goes to INIT.
  - INIT goes to IDLE after the last word.
  - IDLE goes to INIT if init_req is high; otherwise to ACC if any request is high.
  - ACC always goes to WAIT.
  - WAIT takes the same decision as IDLE. This allows back-to-back accesses at one per 2 cycles.
- Init precedence: init_req beats both requesters. init_req seen during INIT is ignored; the sweep neither restarts nor queues.
- Arbitration:
  - Priority pointer, reset 0.
  - Both requesting: grant the pointer's requester.
  - Single request: grant it.
  - After every grant the pointer moves to the other requester.
- Request latching: the granted request's we/addr/wdata are latched at the decision edge. Inputs may change after gnt.
- Writes: done pulses; rdata is unchanged.
- Reads: rdata captures mem_q on the done edge.
- Outputs: every output is registered. When no access or init is in progress, mem_we=0, mem_addr=0 and mem_d=0.

## Timing
- Reset values:
  - busy_init = 1.
  - All other outputs 0, including rdata.
  - mem_we is 0 during reset, so the memory is never written while resetn is low.
- Init sweep (E0 = first edge after resetn rises):
  - After edge E_k (k=0..2^AW-1): mem_we=1, mem_addr=k, mem_d = k if k<INIT_WORDS else 0.
  - After E_(2^AW): busy_init=0, mem_we=0.
  - Sweep takes 2^AW cycles.
- Access (request sampled at edge E):
  - After E: mem_* carry the access and rX_gnt=1 for that cycle.
  - After E+1: mem_we=0.
  - After E+2: rX_done=1 for that cycle, and rX_rdata is valid for reads.
  - Latency is 2 cycles from gnt to done.
- Simultaneous done and next gnt (WAIT to ACC) is legal and required.
- Reset mid-access: the pending done is never asserted, and the sweep restarts from address 0.

## Structure
- Package rom_ctrl_pkg holds:
  - the state enum (INIT, IDLE, ACC, WAIT);
  - default constants AW=5 and DEPTH=32;
  - the INIT_WORDS default.
- Sub-module rr_arbiter2: 2-input round-robin arbiter with pointer register. Inputs req[1:0] and advance; outputs one-hot grant.

## Test plan
- Release reset: exactly 32 write cycles, addresses 0..31, data 0x00..0x0F then 0x00 ×16. busy_init falls one cycle after address 31.
- After init, r0 reads address 5: r0_gnt pulse, r0_done 2 cycles later, r0_rdata=0x05, r1 outputs unchanged.
- r1 writes 0xA5 to address 20, then r0 reads address 20: r0_rdata=0xA5, and r1_rdata remains 0x00.
- r0_req and r1_req both held high for 6 accesses: grants go r0,r1,r0,r1,r0,r1, one every 2 cycles, each done 2 cycles after its gnt.
- init_req and r1_req asserted on the same edge after writing 0xA5 to address 20:
  - the full sweep runs first;
  - r1 is granted on the edge after busy_init falls;
  - a read of address 20 returns 0x00.
- resetn pulsed low between r0_gnt and r0_done:
  - r0_done never asserts;
  - all outputs go to reset values immediately and busy_init=1;
  - a sweep from address 0 follows release.
